dmem_bus: RTL and testbench
===========================

Name: dmem_bus

Overview:
- Parametrised data-side memory subsystem replacing the bare data RAM hookup at the SoC top.
- Sits between the CPU data port and the following targets: byte-masked data RAM, an MMIO block with halt/exit register, 64-bit cycle counter and console TX FIFO.
- Adds a valid/ready request–response handshake with configurable wait states, address decode and a bus-error response.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; multiple of 8; mask width MW = DATA_WIDTH/8
DMEM_WORDS, 8192, RAM depth in words; power of two
DMEM_BASE, 32'h8000_0000, RAM byte base address
MMIO_BASE, 32'hA000_0000, MMIO byte base address; 32-byte window
WAIT_STATES, 0, extra cycles between request accept and response (0..15)
TXQ_DEPTH, 16, console FIFO depth; power of two, at least 2

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address; low log2(MW) bits ignored
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  MW  byte-lane write enables
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data, valid while rsp_valid is high
rsp_err  out  1  decode error, valid while rsp_valid is high
halted  out  1  sticky; set by a write to EXIT
exit_code  out  DATA_WIDTH  value written to EXIT
tx_valid  out  1  console FIFO not empty
tx_data  out  8  FIFO head byte
tx_ready  in  1  sink consumes the head byte when tx_valid is also high

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, halted=0, exit_code=0, tx_valid=0, tx_data=0, cycle counter=0, FIFO empty, overflow flag=0. RAM contents are not reset.
- State machine IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: req_ready=1. A request is accepted on req_valid && req_ready. On accept, the address, we, wdata and mask are captured.
  - From IDLE, go to WAIT if WAIT_STATES > 0, otherwise go straight to RESP.
  - WAIT: req_ready=0. Down-counter loaded with WAIT_STATES-1; go to RESP when it reaches 0.
  - RESP: rsp_valid=1 and req_ready=0 for exactly one cycle, then return to IDLE.
- Latency: accept edge to rsp_valid is WAIT_STATES+1 cycles. Maximum throughput is one request per WAIT_STATES+2 cycles.
- Write timing: RAM and MMIO writes take effect on the accept edge; reads sample on the accept edge. A read of the same address immediately after a write returns the new data.
- RAM decode:
  - Hit when DMEM_BASE <= addr < DMEM_BASE + DMEM_WORDS*MW.
  - Word index = (addr - DMEM_BASE) >> log2(MW).
  - Only lanes with their wmask bit set are written; wmask=0 on a write is a no-op with no error.
- MMIO decode (word offset from MMIO_BASE):
  - 0x00 EXIT: a write sets halted=1 and loads exit_code with wdata (mask ignored). A read returns exit_code.
  - 0x04 TXD: a write pushes wdata[7:0]. If the FIFO is full, the byte is dropped and overflow is set (sticky). A read returns 0.
  - 0x08 CYCLE_LO: read returns the low 32 bits of the cycle counter.
  - 0x0C CYCLE_HI: read returns the high 32 bits.
  - 0x10 STATUS: read returns {overflow at bit 31, FIFO count in the low bits}. A write of any value clears overflow.
  - 0x14..0x1C: read returns 0, writes are ignored, no error.
- Cycle counter: 64-bit, increments every cycle after reset, wraps at 2^64, keeps counting after halt.
  - Latching: reading CYCLE_LO latches the high word, and CYCLE_HI returns that latched value. A LO-then-HI pair is coherent across a carry.
- Any other address: read gives rsp_rdata=0 and rsp_err=1; write has no side effect and gives rsp_err=1.
- When DATA_WIDTH > 32, MMIO reads are zero-extended.
- rsp_rdata is held at its last value outside RESP.
- Console FIFO:
  - Pop on tx_valid && tx_ready; tx_data is the head byte.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
  - A push while full combined with a same-cycle pop is accepted, with no overflow.
  - Pointers wrap modulo TXQ_DEPTH.
- Halt: halted does not block further requests; the CPU or testbench decides when to stop.
- Reset mid-transaction: an in-flight request is abandoned, no rsp_valid is produced, and FIFO contents are lost.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF mask 4'hF to 0x8000_0010, then read it -> rsp_valid 1 cycle after each accept; rdata=0xDEADBEEF, err=0.
- Byte mask: over 0xDEADBEEF, write 0x0000_AA00 mask 4'b0010, then read -> 0xDEADAAEF.
- WAIT_STATES=3: read with req_valid held high -> req_ready low for 4 cycles, rsp_valid exactly 4 cycles after accept, next accept on the cycle after RESP.
- Console, tx_ready=0: write 0x41..0x50 (16 bytes) then 0x51 to TXD -> STATUS=0x8000_0010; raise tx_ready -> 0x41..0x50 emitted in order, 0x51 absent.
- Write 0x0000_0007 to EXIT -> halted=1, exit_code=7. Read 0x1234_0000 -> rdata=0, rsp_err=1.
- Force counter to 0x0000_0000_FFFF_FFFE, read LO then HI -> LO=0xFFFF_FFFE, HI=0 (latched). Then assert rst during WAIT -> no rsp_valid, all outputs at reset values.

Source files
------------

// File: rtl/dmem_bus.sv
// Data-side bus: valid/ready request, one-cycle response WAIT_STATES+1 cycles after accept,
// decoding to byte-masked RAM and MMIO (exit, 64-bit cycle counter, console TX FIFO).
module dmem_bus #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DMEM_WORDS  = 8192,
    parameter logic [ADDR_WIDTH-1:0] DMEM_BASE   = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 32'hA000_0000,
    parameter int                    WAIT_STATES = 0,
    parameter int                    TXQ_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    halted,
    output logic [DATA_WIDTH-1:0]   exit_code,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready
);
    localparam int MW        = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(MW);
    localparam int IDX_BITS  = $clog2(DMEM_WORDS);
    localparam int PTR_BITS  = $clog2(TXQ_DEPTH);
    localparam logic [ADDR_WIDTH:0]   RAM_BYTES  = (ADDR_WIDTH+1)'(DMEM_WORDS * MW);
    localparam logic [ADDR_WIDTH-1:0] MMIO_BYTES = ADDR_WIDTH'(32);
    localparam logic [3:0]            WCNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [PTR_BITS:0]     TXQ_FULL   = (PTR_BITS+1)'(TXQ_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_state_nx;
    logic [3:0]            r_wcnt;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_ram_off, w_mmio_off;
    logic                  w_ram_hit, w_mmio_hit;
    logic [IDX_BITS-1:0]   w_ram_idx;
    logic [2:0]            w_reg_sel;
    logic [DATA_WIDTH-1:0] w_rdata, r_rd_cap, r_rsp_rdata;
    logic                  w_err, r_err_cap, r_rsp_err;
    logic [DATA_WIDTH-1:0] r_mem [DMEM_WORDS];
    logic [63:0]           r_cycle;
    logic [31:0]           r_hi_latch;
    logic                  r_halted;
    logic [DATA_WIDTH-1:0] r_exit_code;
    logic [7:0]            r_txq [TXQ_DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_BITS:0]     r_tx_cnt;
    logic                  r_ovf;
    logic                  w_mmio_wr, w_wr_exit, w_wr_txd, w_wr_status, w_rd_lo;
    logic                  w_push, w_pop, w_full;
    logic [31:0]           w_status;

    assign w_accept   = req_valid && req_ready;
    assign w_ram_off  = req_addr - DMEM_BASE;
    assign w_mmio_off = req_addr - MMIO_BASE;
    assign w_ram_hit  = (req_addr >= DMEM_BASE) && ({1'b0, w_ram_off} < RAM_BYTES);
    assign w_mmio_hit = (req_addr >= MMIO_BASE) && (w_mmio_off < MMIO_BYTES);
    assign w_ram_idx  = w_ram_off[LANE_BITS +: IDX_BITS];
    assign w_reg_sel  = w_mmio_off[4:2];

    assign w_mmio_wr   = w_accept && req_we && w_mmio_hit;
    assign w_wr_exit   = w_mmio_wr && (w_reg_sel == 3'd0);
    assign w_wr_txd    = w_mmio_wr && (w_reg_sel == 3'd1);
    assign w_wr_status = w_mmio_wr && (w_reg_sel == 3'd4);
    assign w_rd_lo     = w_accept && !req_we && w_mmio_hit && (w_reg_sel == 3'd2);

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_full   = (r_tx_cnt == TXQ_FULL);
    assign w_pop    = tx_valid && tx_ready;
    assign w_push   = w_wr_txd && (!w_full || w_pop);
    assign w_status = {r_ovf, 31'(r_tx_cnt)};

    assign tx_valid  = (r_tx_cnt != '0);
    assign tx_data   = tx_valid ? r_txq[r_rd_ptr] : 8'h00;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign halted    = r_halted;
    assign exit_code = r_exit_code;

    always_comb begin
        w_state_nx = r_state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) w_state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: if (r_wcnt == 4'd0) w_state_nx = S_RESP;
            S_RESP: begin
                rsp_valid  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_ram_hit) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_reg_sel)
                3'd0:    w_rdata = r_exit_code;
                3'd2:    w_rdata = DATA_WIDTH'(r_cycle[31:0]);
                3'd3:    w_rdata = DATA_WIDTH'(r_hi_latch);
                3'd4:    w_rdata = DATA_WIDTH'(w_status);
                default: w_rdata = '0;
            endcase
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_rd_cap    <= '0;
            r_err_cap   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cycle     <= 64'd0;
            r_hi_latch  <= 32'd0;
            r_halted    <= 1'b0;
            r_exit_code <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tx_cnt    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cycle <= r_cycle + 64'd1;
            if (w_accept) begin
                r_wcnt    <= WCNT_INIT;
                r_rd_cap  <= w_rdata;
                r_err_cap <= w_err;
            end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            // Zero wait states go straight from accept to RESP, bypassing the capture.
            if (w_state_nx == S_RESP) begin
                r_rsp_rdata <= (r_state == S_IDLE) ? w_rdata : r_rd_cap;
                r_rsp_err   <= (r_state == S_IDLE) ? w_err : r_err_cap;
            end
            if (w_rd_lo) r_hi_latch <= r_cycle[63:32];
            if (w_wr_exit) begin
                r_halted    <= 1'b1;
                r_exit_code <= req_wdata;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            case ({w_push, w_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (PTR_BITS+1)'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (PTR_BITS+1)'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (w_wr_status)                       r_ovf <= 1'b0;
            else if (w_wr_txd && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && req_we && w_ram_hit) begin
            for (int i = 0; i < MW; i++) begin
                if (req_wmask[i]) r_mem[w_ram_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
        if (w_push) r_txq[r_wr_ptr] <= req_wdata[7:0];
    end
endmodule

// File: tb/tb_dmem_bus.sv
// Scoreboard bench for dmem_bus: two instances (0 and 3 wait states), expected responses
// queued at issue time and checked by independent response and console monitors.
module tb_dmem_bus;
    localparam int WS_OF [2] = '{0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        halted    [2];
    logic [31:0] exit_code [2];
    logic        tx_valid  [2];
    logic [7:0]  tx_data   [2];
    logic        tx_ready  [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          acc;
        string       name;
    } exp_t;

    exp_t       q0[$], q1[$];
    logic [7:0] txq[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         last_acc [2];
    int         last_wait [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bus #(.DMEM_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .halted(halted[0]), .exit_code(exit_code[0]),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]));

    dmem_bus #(.DMEM_WORDS(256), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .halted(halted[1]), .exit_code(exit_code[1]),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic check_rsp(input int d);
        exp_t e;
        bit   have = 1'b0;
        if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
        if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
            n_checks++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 rdata=0x%08h, required no response",
                     d, rsp_rdata[d]);
        end else begin
            if (e.chk_rd) check({e.name, " rdata"}, 64'(rsp_rdata[d]), 64'(e.rdata));
            check({e.name, " err"}, 64'(rsp_err[d]), 64'(e.err));
            check({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(WS_OF[d] + 1));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && rsp_valid[d]) check_rsp(d);
        end
    end

    always @(negedge clk) begin
        if (!rst && tx_valid[0] && tx_ready[0]) begin
            if (txq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_tx: got byte 0x%02h, required none", tx_data[0]);
            end else begin
                check("tx byte", 64'(tx_data[0]), 64'(txq.pop_front()));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [31:0] exp_rdata, input logic exp_err,
                         input string name);
        exp_t e;
        int   guard = 0;
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_wmask[d] = mask;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready[d]) begin
            n_checks++;
            $display("FAIL %s accept: got req_ready=0 for %0d cycles, required 1", name, guard);
            req_valid[d] = 1'b0;
            return;
        end
        e.rdata = exp_rdata; e.err = exp_err; e.chk_rd = !we; e.acc = cyc + 1; e.name = name;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        last_acc[d]  = cyc + 1;
        last_wait[d] = guard;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, " req_ready"}, 64'(req_ready[d]), 64'd1);
        check({tag, " rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata[d]), 64'd0);
        check({tag, " rsp_err"},   64'(rsp_err[d]),   64'd0);
        check({tag, " halted"},    64'(halted[d]),    64'd0);
        check({tag, " exit_code"}, 64'(exit_code[d]), 64'd0);
        check({tag, " tx_valid"},  64'(tx_valid[d]),  64'd0);
        check({tag, " tx_data"},   64'(tx_data[d]),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wmask[d] = '0; tx_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset dut0");
        check_reset_outputs(1, "reset dut3");

        rst = 1'b0;
        issue(0, 1'b0, 32'hA000_0008, '0, 4'h0, 32'h0, 1'b0, "cycle_lo first");
        issue(0, 1'b0, 32'hA000_0008, '0, 4'h0, 32'h2, 1'b0, "cycle_lo second");

        issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, '0, 1'b0, "ram wr full");
        issue(0, 1'b0, 32'h8000_0010, '0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ram rd full");
        issue(0, 1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, '0, 1'b0, "ram wr lane1");
        issue(0, 1'b0, 32'h8000_0010, '0, 4'h0, 32'hDEAD_AAEF, 1'b0, "ram rd lane1");
        issue(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, '0, 1'b0, "ram wr nomask");
        issue(0, 1'b0, 32'h8000_0013, '0, 4'h0, 32'hDEAD_AAEF, 1'b0, "ram rd unaligned");
        issue(0, 1'b1, 32'h8000_03FC, 32'hCAFE_F00D, 4'hF, '0, 1'b0, "ram wr last");
        issue(0, 1'b0, 32'h8000_03FC, '0, 4'h0, 32'hCAFE_F00D, 1'b0, "ram rd last");
        issue(0, 1'b0, 32'h8000_0400, '0, 4'h0, 32'h0, 1'b1, "rd past ram");
        issue(0, 1'b0, 32'h7FFF_FFFC, '0, 4'h0, 32'h0, 1'b1, "rd below ram");

        issue(0, 1'b1, 32'hA000_0000, 32'h0000_0007, 4'h0, '0, 1'b0, "exit wr");
        drain();
        check("halted", 64'(halted[0]), 64'd1);
        check("exit_code", 64'(exit_code[0]), 64'd7);
        issue(0, 1'b0, 32'hA000_0000, '0, 4'h0, 32'h7, 1'b0, "exit rd");
        issue(0, 1'b0, 32'h1234_0000, '0, 4'h0, 32'h0, 1'b1, "unmapped rd");
        issue(0, 1'b1, 32'h1234_0000, 32'hFFFF_FFFF, 4'hF, '0, 1'b1, "unmapped wr");
        issue(0, 1'b0, 32'hA000_0020, '0, 4'h0, 32'h0, 1'b1, "rd past mmio");
        issue(0, 1'b0, 32'hA000_0014, '0, 4'h0, 32'h0, 1'b0, "rd reserved");
        issue(0, 1'b0, 32'hA000_0004, '0, 4'h0, 32'h0, 1'b0, "rd txd");

        for (int b = 8'h41; b <= 8'h51; b++) begin
            if (b <= 8'h50) txq.push_back(8'(b));
            issue(0, 1'b1, 32'hA000_0004, 32'(b), 4'h1, '0, 1'b0, "txd wr");
        end
        issue(0, 1'b0, 32'hA000_0010, '0, 4'h0, 32'h8000_0010, 1'b0, "status full");
        drain();
        @(posedge clk);
        #1 tx_ready[0] = 1'b1;
        for (int g = 0; g < 100 && txq.size() != 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("tx bytes left", 64'(txq.size()), 64'd0);
        check("tx_valid drained", 64'(tx_valid[0]), 64'd0);
        issue(0, 1'b0, 32'hA000_0010, '0, 4'h0, 32'h8000_0000, 1'b0, "status sticky");
        issue(0, 1'b1, 32'hA000_0010, 32'h0, 4'hF, '0, 1'b0, "status clear");
        issue(0, 1'b0, 32'hA000_0010, '0, 4'h0, 32'h0, 1'b0, "status cleared");

        force u_dut0.r_cycle = 64'h0000_0000_FFFF_FFFE;
        issue(0, 1'b0, 32'hA000_0008, '0, 4'h0, 32'hFFFF_FFFE, 1'b0, "cycle_lo carry");
        release u_dut0.r_cycle;
        repeat (3) @(negedge clk);
        issue(0, 1'b0, 32'hA000_000C, '0, 4'h0, 32'h0, 1'b0, "cycle_hi latched");
        issue(0, 1'b0, 32'hA000_000C, '0, 4'h0, 32'h0, 1'b0, "cycle_hi again");
        drain();

        issue(1, 1'b1, 32'h8000_0000, 32'h1111_2222, 4'hF, '0, 1'b0, "ws3 wr");
        issue(1, 1'b0, 32'h8000_0000, '0, 4'h0, 32'h1111_2222, 1'b0, "ws3 rd a");
        acc1 = last_acc[1];
        issue(1, 1'b0, 32'h8000_0000, '0, 4'h0, 32'h1111_2222, 1'b0, "ws3 rd b");
        check("ws3 ready low cycles", 64'(last_wait[1]), 64'd4);
        check("ws3 accept spacing", 64'(last_acc[1] - acc1), 64'd5);
        drain();

        issue(1, 1'b0, 32'h8000_0000, '0, 4'h0, 32'h1111_2222, 1'b0, "ws3 abandoned");
        @(negedge clk);
        rst = 1'b1;
        q1.delete();
        #1;
        check_reset_outputs(1, "midrst dut3");
        check_reset_outputs(0, "midrst dut0");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post reset req_ready", 64'(req_ready[1]), 64'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
